// File: rtl/bus_master_lsu.sv
// Load/store initiator for the byte-serial memory bus: one request, one bus
// transaction. Load data is extended here; a timeout guards against a silent bus.
module bus_master_lsu #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_bus_data,
    output logic [31:0] o_bus_address,
    output logic        o_bus_DV,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Unsigned variants only make sense for loads.
    function automatic logic req_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: req_legal = 1'b1;
            F3_BU, F3_HU:     req_legal = ~we;
            default:          req_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] byte_count(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: byte_count = 3'd1;
            F3_H, F3_HU: byte_count = 3'd2;
            default:     byte_count = 3'd4;
        endcase
    endfunction

    // The bus shifts bytes out MSB first, so narrow stores are left-justified.
    function automatic logic [31:0] store_lane(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    store_lane = {d[7:0], 24'h0};
            F3_H:    store_lane = {d[15:0], 16'h0};
            default: store_lane = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    load_extend = {{24{d[7]}}, d[7:0]};
            F3_BU:   load_extend = {24'h0, d[7:0]};
            F3_H:    load_extend = {{16{d[15]}}, d[15:0]};
            F3_HU:   load_extend = {16'h0, d[15:0]};
            default: load_extend = d;
        endcase
    endfunction

    state_t          state_reg, state_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic [2:0]      funct3_reg, funct3_next;
    logic [31:0]     bus_addr_reg, bus_addr_next;
    logic [31:0]     bus_data_reg, bus_data_next;
    logic [2:0]      bhw_reg, bhw_next;
    logic            wnr_reg, wnr_next;
    logic            bus_dv_reg, bus_dv_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;
    logic [31:0]     rdata_reg, rdata_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            to_cnt_reg   <= '0;
            funct3_reg   <= '0;
            bus_addr_reg <= '0;
            bus_data_reg <= '0;
            bhw_reg      <= '0;
            wnr_reg      <= 1'b0;
            bus_dv_reg   <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            to_cnt_reg   <= to_cnt_next;
            funct3_reg   <= funct3_next;
            bus_addr_reg <= bus_addr_next;
            bus_data_reg <= bus_data_next;
            bhw_reg      <= bhw_next;
            wnr_reg      <= wnr_next;
            bus_dv_reg   <= bus_dv_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            rdata_reg    <= rdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        to_cnt_next   = to_cnt_reg;
        funct3_next   = funct3_reg;
        bus_addr_next = bus_addr_reg;
        bus_data_next = bus_data_reg;
        bhw_next      = bhw_reg;
        wnr_next      = wnr_reg;
        bus_dv_next   = 1'b0;
        done_next     = 1'b0;
        err_next      = 1'b0;
        rdata_next    = rdata_reg;

        case (state_reg)
            ST_IDLE: begin
                // Stray or late bus completions are ignored here.
                to_cnt_next = '0;
                if (i_req) begin
                    if (req_legal(i_funct3, i_we)) begin
                        state_next    = ST_WAIT;
                        funct3_next   = i_funct3;
                        bus_addr_next = i_addr;
                        wnr_next      = i_we;
                        bhw_next      = byte_count(i_funct3);
                        bus_data_next = i_we ? store_lane(i_funct3, i_wdata) : 32'h0;
                        bus_dv_next   = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Completion takes priority over a timeout in the same cycle.
                if (i_bus_DV) begin
                    state_next  = ST_IDLE;
                    to_cnt_next = '0;
                    done_next   = 1'b1;
                    if (!wnr_reg) begin
                        rdata_next = load_extend(funct3_reg, i_bus_data);
                    end
                end else if (to_cnt_reg == TO_LAST) begin
                    state_next  = ST_IDLE;
                    to_cnt_next = '0;
                    err_next    = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            default: begin
                state_next  = ST_IDLE;
                to_cnt_next = '0;
            end
        endcase
    end

    assign o_busy          = (state_reg != ST_IDLE);
    assign o_done          = done_reg;
    assign o_err           = err_reg;
    assign o_rdata         = rdata_reg;
    assign o_bus_data      = bus_data_reg;
    assign o_bus_address   = bus_addr_reg;
    assign o_bus_DV        = bus_dv_reg;
    assign o_bhw           = bhw_reg;
    assign o_write_notread = wnr_reg;

endmodule

// File: doc/bus_master_lsu.md
Name: bus_master_lsu

Overview:
- CPU-side initiator for the byte-serial memory bus.
- Converts one load/store request from the execute stage into a single bus transaction: bus request pulse, byte count, left-justified store data.
- Waits for the memory subsystem's completion pulse, then returns sign- or zero-extended load data to the core.
- Sits between the pipeline's memory stage and the memory top; stalls the core via o_busy.

Parameters:
TIMEOUT_CYCLES, 4096, cycles spent in WAIT without bus completion before the access is aborted with o_err.
TO_W, 13, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst  in  1  asynchronous active-high reset
i_req  in  1  access request from core, sampled in IDLE only
i_we  in  1  1 = store, 0 = load
i_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
i_addr  in  32  byte address; any alignment is legal
i_wdata  in  32  store data, right-justified
o_busy  out  1  high whenever state != IDLE
o_done  out  1  one-cycle pulse: access complete
o_err  out  1  one-cycle pulse: illegal funct3 or timeout
o_rdata  out  32  extended load data, valid from o_done, held until next o_done
o_bus_data  out  32  store data to memory, left-justified
o_bus_address  out  32  start byte address
o_bus_DV  out  1  one-cycle request pulse
o_bhw  out  3  byte count: 1, 2 or 4
o_write_notread  out  1  1 = write
i_bus_data  in  32  read data from memory; byte k (addr+k) in bits [8k+7:8k]
i_bus_DV  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0, including o_rdata and the timeout counter. Reset mid-access aborts it without o_done/o_err.
- States are IDLE, WAIT.
- IDLE with i_req=1, legal funct3:
  - Next edge registers o_bus_address=i_addr and o_write_notread=i_we.
  - o_bhw is 3'd1 for B/BU, 3'd2 for H/HU, 3'd4 for W.
  - o_bus_data for W stores = i_wdata; H = {i_wdata[15:0],16'h0}; B = {i_wdata[7:0],24'h0}; loads = 0.
  - o_bus_DV=1 for exactly that one cycle; state goes to WAIT; funct3 and we are latched internally.
- Illegal funct3: 011, 110, 111 in either direction, and 100/101 with i_we=1. No bus transaction; o_err pulses the next cycle; state stays IDLE.
- WAIT:
  - o_bus_address, o_bus_data, o_bhw and o_write_notread are held stable.
  - The timeout counter increments each cycle.
  - i_bus_DV=1 → next edge: o_done=1 for one cycle, state IDLE, counter cleared.
  - Load results in o_rdata: B = sext(i_bus_data[7:0]); BU = zext(i_bus_data[7:0]); H = sext(i_bus_data[15:0]); HU = zext(i_bus_data[15:0]); W = i_bus_data.
  - Upper bus bytes beyond the byte count are undefined and always discarded.
  - On stores, o_rdata is unchanged.
- Timeout: when the counter reaches TIMEOUT_CYCLES-1 without i_bus_DV → next edge: o_err pulse, state IDLE, counter cleared, no o_done. If i_bus_DV arrives in that same cycle, completion wins.
- i_bus_DV in IDLE (stray, or late after timeout/reset) is ignored; o_rdata is not modified.
- i_req while busy is ignored; the core must hold i_req until it sees o_done/o_err.
- A new i_req in the o_done cycle is accepted; the earliest back-to-back o_bus_DV spacing is 3 cycles.
- Only one outstanding transaction at any time; the memory side accepts requests only while idle.
- Latency: i_req edge → o_bus_DV +1 cycle; i_bus_DV → o_done +1 cycle.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, responder completes 5 cycles later → o_bus_DV single pulse; bhw=4, write=1, bus_data=0xDEADBEEF; o_done pulses 1 cycle after i_bus_DV; o_busy high for 6 cycles.
- SB addr=0x103, wdata=0x000000A5 → bus_data=0xA5000000, bhw=1; SH wdata=0x1234 → bus_data=0x12340000, bhw=2.
- LB with i_bus_data=0xFFFFFF80 → o_rdata=0xFFFFFF80; LBU → 0x00000080; LH with i_bus_data=0xAAAA8001 → 0xFFFF8001; LHU → 0x00008001; LW with i_bus_data=0x01020304 → 0x01020304.
- funct3=011 load, and funct3=100 with i_we=1 → no o_bus_DV, o_err pulse the next cycle, o_busy stays 0.
- TIMEOUT_CYCLES=8, responder never answers → o_err at cycle 9 after o_bus_DV; a stray i_bus_DV 2 cycles later leaves o_rdata/o_done untouched; next request proceeds normally.
- Assert i_rst during WAIT, release, then issue an LW → all outputs 0 during reset; the new transaction completes normally; i_req held through busy yields exactly one bus transaction.
